// File: rtl/piece_draw_sequencer.sv
// Repaints a tetromino through the shared box renderer: optional erase of the
// old four cells in BG_COLOR, then the new four cells in the piece colour.
module piece_draw_sequencer #(
    parameter int         CELL     = 24,
    parameter int         GRID_X0  = 200,
    parameter int         GRID_Y0  = 0,
    parameter int         NCOLS    = 10,
    parameter int         NROWS    = 20,
    parameter logic [8:0] BG_COLOR = 9'h000
) (
    input  logic        CLOCK_50,
    input  logic        resetn,
    input  logic        req,
    input  logic        erase_en,
    input  logic [35:0] old_cells,
    input  logic [35:0] new_cells,
    input  logic [8:0]  piece_color,
    output logic        busy,
    output logic        done,
    output logic        box_start,
    output logic [9:0]  box_x0,
    output logic [8:0]  box_y0,
    output logic [8:0]  box_color,
    input  logic        box_done,
    output logic [3:0]  cells_drawn
);

    typedef enum logic [2:0] {S_IDLE, S_SEL, S_ISSUE, S_WAIT, S_FIN} state_t;

    localparam logic [9:0] CELL_W  = 10'(CELL);
    localparam logic [4:0] NCOLS_W = 5'(NCOLS);
    localparam logic [5:0] NROWS_W = 6'(NROWS);

    state_t          state_q, state_d;
    logic [2:0]      idx_q, idx_d;
    logic [3:0][8:0] old_q, old_d, new_q, new_d;
    logic [8:0]      color_q, color_d;
    logic [9:0]      x_q, x_d;
    logic [8:0]      y_q, y_d;
    logic [8:0]      bc_q, bc_d;
    logic [3:0]      cnt_q, cnt_d;

    logic [8:0]      sel_cell;
    logic [3:0]      sel_col;
    logic [4:0]      sel_row;
    logic            on_grid;
    logic [9:0]      px;
    logic [8:0]      py;

    // Constant multiply by CELL as a sum of shifted copies of the operand.
    function automatic logic [9:0] mul_cell(input logic [9:0] v);
        logic [9:0] acc;
        acc = '0;
        for (int b = 0; b < 10; b++)
            if (CELL_W[b]) acc = acc + (v << b);
        return acc;
    endfunction

    // idx 0..3 walks the old cells, 4..7 the new cells.
    assign sel_cell = idx_q[2] ? new_q[idx_q[1:0]] : old_q[idx_q[1:0]];
    assign sel_col  = sel_cell[3:0];
    assign sel_row  = sel_cell[8:4];
    assign on_grid  = ({1'b0, sel_col} < NCOLS_W) && ({1'b0, sel_row} < NROWS_W);
    assign px       = 10'(GRID_X0) + mul_cell({6'b0, sel_col});
    assign py       = 9'(GRID_Y0) + 9'(mul_cell({5'b0, sel_row}));

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            old_q   <= '0;
            new_q   <= '0;
            color_q <= '0;
            x_q     <= '0;
            y_q     <= '0;
            bc_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            old_q   <= old_d;
            new_q   <= new_d;
            color_q <= color_d;
            x_q     <= x_d;
            y_q     <= y_d;
            bc_q    <= bc_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        old_d   = old_q;
        new_d   = new_q;
        color_d = color_q;
        x_d     = x_q;
        y_d     = y_q;
        bc_d    = bc_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    old_d   = old_cells;
                    new_d   = new_cells;
                    color_d = piece_color;
                    idx_d   = erase_en ? 3'd0 : 3'd4;
                    cnt_d   = '0;
                    state_d = S_SEL;
                end
            end
            S_SEL: begin
                if (on_grid) begin
                    x_d     = px;
                    y_d     = py;
                    bc_d    = idx_q[2] ? color_q : BG_COLOR;
                    state_d = S_ISSUE;
                end else if (idx_q == 3'd7) begin
                    state_d = S_FIN;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            S_ISSUE: begin
                cnt_d   = cnt_q + 4'd1;
                state_d = S_WAIT;
            end
            // Coordinates stay frozen here; the renderer reads them every pixel.
            S_WAIT: begin
                if (box_done) begin
                    if (idx_q == 3'd7) begin
                        state_d = S_FIN;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = S_SEL;
                    end
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign busy        = (state_q == S_SEL) || (state_q == S_ISSUE) || (state_q == S_WAIT);
    assign box_start   = (state_q == S_ISSUE);
    assign done        = (state_q == S_FIN);
    assign box_x0      = x_q;
    assign box_y0      = y_q;
    assign box_color   = bc_q;
    assign cells_drawn = cnt_q;

endmodule

// File: doc/piece_draw_sequencer.md
Name: piece_draw_sequencer

Overview:
Controller that sequences the 24x24 box renderer to repaint a tetromino on the playfield. On a request it optionally erases the piece's old four cells in the background colour, then draws the new four cells in the piece colour. It converts grid (col,row) to pixel top-left coordinates and handshakes each cell through the renderer's start/done. It sits between game logic and the single box renderer instance.

Parameters:
CELL, 24, cell edge in pixels (renderer box size)
GRID_X0, 200, pixel X of playfield column 0
GRID_Y0, 0, pixel Y of playfield row 0
NCOLS, 10, playfield columns; col >= NCOLS is off-grid
NROWS, 20, playfield rows; row >= NROWS is off-grid
BG_COLOR, 9'h000, erase colour (RRR_GGG_BBB)

Ports:
CLOCK_50  in  1  clock
resetn  in  1  synchronous active-low reset
req  in  1  request; sampled only in IDLE
erase_en  in  1  1 = erase old cells before drawing new
old_cells  in  36  4 cells, cell i = [9i+8:9i] = {row[4:0], col[3:0]}
new_cells  in  36  same packing
piece_color  in  9  draw colour for new cells
busy  out  1  high from capture until done pulse (inclusive of done cycle: no)
done  out  1  one-cycle pulse when sequence complete
box_start  out  1  one-cycle start pulse to renderer
box_x0  out  10  renderer top-left X
box_y0  out  9  renderer top-left Y
box_color  out  9  renderer colour
box_done  in  1  renderer completion pulse
cells_drawn  out  4  count of start pulses issued in last/current sequence

Behaviour:
- Reset (resetn=0 at posedge): state IDLE; busy, done, box_start = 0; box_x0, box_y0, box_color, cells_drawn = 0; captured cell/colour registers cleared. Reset mid-sequence abandons it; no done pulse.
- States: IDLE, SEL, ISSUE, WAIT, FIN.
- IDLE: if req=1, capture old_cells, new_cells, piece_color, erase_en into registers; idx <= 0 if erase_en else 4; cells_drawn <= 0; go SEL. busy=1 from next cycle. Inputs may change after capture.
- idx 0..3 select old cell idx with BG_COLOR; idx 4..7 select new cell idx-4 with captured piece_color.
- SEL: if selected cell col < NCOLS and row < NROWS: register box_x0 = GRID_X0 + col*CELL, box_y0 = GRID_Y0 + row*CELL, box_color; go ISSUE. Else (off-grid) skip: if idx=7 go FIN else idx+1, stay SEL. One cycle per cell evaluated.
- Multiply by shift-add (col*24 = col<<4 + col<<3); result truncated to port width (10/9 bits); defaults never overflow (max X 416+23, max Y 456+23).
- ISSUE: box_start=1 for exactly one cycle; cells_drawn +1; go WAIT.
- WAIT: box_x0/y0/color held constant (renderer reads them every pixel). On box_done=1: if idx=7 go FIN else idx+1, go SEL.
- FIN: done=1 for one cycle, busy=0; go IDLE. Next req accepted the cycle after FIN.
- req while busy: ignored (not queued). box_done in IDLE/SEL/ISSUE: ignored.
- box_done in same cycle as box_start (ISSUE): ignored; only WAIT consumes done.
- erase_en=0: only 4 new cells; all 8 off-grid: no box_start, done 5 (or 9) cycles after capture.
- Latency per on-grid cell: SEL(1) + ISSUE(1) + renderer time until box_done + 1.
- No timeout: a missing box_done holds WAIT until reset.

Test Plan:
- Draw only: erase_en=0, new cells (0,0),(1,0),(2,0),(1,1) colour 9'h1C0, renderer model done 10 cycles after start -> 4 start pulses with (x0,y0)=(200,0),(224,0),(248,0),(224,24), box_color 9'h1C0, single done pulse, cells_drawn=4.
- Erase+draw: erase_en=1, old (4,5)x4 layout, new shifted row+1 -> 8 starts, first 4 colour 9'h000 at y0=120, last 4 colour piece, order idx 0..7.
- Off-grid skip: new cells with col=10 and row=20 plus two valid -> exactly 2 starts, cells_drawn=2, done asserted; all off-grid -> zero starts, done 5 cycles after req.
- Hold/ignore: req pulsed again during WAIT, box_done injected during ISSUE and IDLE -> no extra start, no state change; box_x0/y0 stable across WAIT.
- Reset mid-WAIT: resetn=0 one cycle -> all outputs 0 next edge, no done; new req then completes normally.
- Corner coords: cell (9,19) -> x0=416, y0=456.
